// File: rtl/dist_pkg.sv
// Shared types and sizing for the distance-bank row packer.
// Holds the FSM state encoding, default geometry and chunk-count helpers.
package dist_pkg;

    localparam int D_DEF          = 256;
    localparam int BW_DEF         = 1;
    localparam int IN_W_DEF       = 16;
    localparam int ADDR_SPACE_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int calc_cpw(input int d, input int bw, input int in_w);
        return (d * bw) / in_w;
    endfunction

    // A single-chunk row still needs a 1-bit counter to stay a legal vector.
    function automatic int calc_cnt_w(input int cpw);
        return (cpw > 1) ? $clog2(cpw) : 1;
    endfunction

    localparam int CPW   = calc_cpw(D_DEF, BW_DEF, IN_W_DEF);
    localparam int CNT_W = calc_cnt_w(CPW);

endpackage

// File: rtl/dist_bank_row_packer_if.sv
// Job control, chunk stream and SRAM write bus of the row packer.
// master drives jobs and chunks; slave is the packer itself.
interface dist_bank_row_packer_if
    import dist_pkg::*;
#(
    parameter int D          = D_DEF,
    parameter int BW         = BW_DEF,
    parameter int IN_W       = IN_W_DEF,
    parameter int ADDR_SPACE = ADDR_SPACE_DEF
);

    logic                  start;
    logic [ADDR_SPACE-1:0] base_addr;
    logic [ADDR_SPACE:0]   num_words;
    logic                  in_valid;
    logic [IN_W-1:0]       in_data;
    logic                  in_ready;
    logic                  wsb;
    logic [ADDR_SPACE-1:0] waddr;
    logic [D*BW-1:0]       wdata;
    logic                  busy;
    logic                  done;

    modport master (
        output start, base_addr, num_words, in_valid, in_data,
        input  in_ready, wsb, waddr, wdata, busy, done
    );

    modport slave (
        input  start, base_addr, num_words, in_valid, in_data,
        output in_ready, wsb, waddr, wdata, busy, done
    );

endinterface

// File: rtl/dist_chunk_shreg.sv
// Pack register: shifts IN_W-bit chunks in at the LSB end so the first
// chunk of a row finishes in the MSBs. row_next is the value after a load.
module dist_chunk_shreg #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] row_next
);

    logic [OUT_W-1:0] row;

    generate
        if (OUT_W > IN_W) begin : g_shift
            assign row_next = {row[OUT_W-IN_W-1:0], din};
        end else begin : g_single
            assign row_next = din;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
        end else if (clear) begin
            row <= '0;
        end else if (load) begin
            row <= row_next;
        end
    end

endmodule

// File: rtl/dist_bank_row_packer.sv
// Packs a chunk stream into D*BW-bit rows and writes them to the distance
// SRAM bank at consecutive addresses from a programmed base.
module dist_bank_row_packer
    import dist_pkg::*;
#(
    parameter int D          = D_DEF,
    parameter int BW         = BW_DEF,
    parameter int IN_W       = IN_W_DEF,
    parameter int ADDR_SPACE = ADDR_SPACE_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    dist_bank_row_packer_if.slave   bus
);

    localparam int ROW_W = D * BW;
    localparam int CPW_L = calc_cpw(D, BW, IN_W);
    localparam int CNT_L = calc_cnt_w(CPW_L);
    localparam logic [CNT_L-1:0]    LAST_CHUNK = CNT_L'(CPW_L - 1);
    localparam logic [ADDR_SPACE:0] ROW_ONE    = (ADDR_SPACE+1)'(1);

    generate
        if ((ROW_W % IN_W) != 0) begin : g_bad_geometry
            $error("dist_bank_row_packer: D*BW must be a multiple of IN_W");
        end
    endgenerate

    state_t                state;
    state_t                state_next;
    logic [CNT_L-1:0]      chunk_cnt;
    logic [ADDR_SPACE-1:0] addr_cnt;
    logic [ADDR_SPACE:0]   row_cnt;
    logic [ADDR_SPACE:0]   rows_total;
    logic                  accept;
    logic                  last_chunk;
    logic                  shreg_clear;
    logic [ROW_W-1:0]      row_next;

    // in_ready is a registered copy of (state == FILL), so gate on state directly.
    assign accept      = (state == FILL) && bus.in_valid;
    assign last_chunk  = accept && (chunk_cnt == LAST_CHUNK);
    assign shreg_clear = ((state == IDLE) && bus.start) || (state == WRITE);

    dist_chunk_shreg #(
        .IN_W  (IN_W),
        .OUT_W (ROW_W)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .clear    (shreg_clear),
        .load     (accept),
        .din      (bus.in_data),
        .row_next (row_next)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = (bus.num_words == '0) ? DONE : FILL;
            FILL:    if (last_chunk) state_next = WRITE;
            WRITE:   state_next = ((row_cnt + ROW_ONE) == rows_total) ? DONE : FILL;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            chunk_cnt    <= '0;
            addr_cnt     <= '0;
            row_cnt      <= '0;
            rows_total   <= '0;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.wsb      <= 1'b1;
            bus.waddr    <= '0;
            bus.wdata    <= '0;
        end else begin
            state        <= state_next;
            bus.in_ready <= (state_next == FILL);
            bus.busy     <= (state_next == FILL) || (state_next == WRITE);
            bus.done     <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr_cnt   <= bus.base_addr;
                        rows_total <= bus.num_words;
                        row_cnt    <= '0;
                        chunk_cnt  <= '0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        chunk_cnt <= chunk_cnt + 1'b1;
                        if (last_chunk) begin
                            bus.wsb   <= 1'b0;
                            bus.waddr <= addr_cnt;
                            bus.wdata <= row_next;
                        end
                    end
                end
                WRITE: begin
                    bus.wsb   <= 1'b1;
                    row_cnt   <= row_cnt + ROW_ONE;
                    addr_cnt  <= addr_cnt + 1'b1;
                    chunk_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dist_bank_row_packer.sv
// Directed bench for dist_bank_row_packer: a posedge monitor logs accepts,
// bank writes and done pulses, and each scenario task checks those logs.
module tb_dist_bank_row_packer;
    import dist_pkg::*;

    localparam int ROW_W = D_DEF * BW_DEF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dist_bank_row_packer_if #(
        .D(D_DEF), .BW(BW_DEF), .IN_W(IN_W_DEF), .ADDR_SPACE(ADDR_SPACE_DEF)
    ) bus ();

    dist_bank_row_packer #(
        .D(D_DEF), .BW(BW_DEF), .IN_W(IN_W_DEF), .ADDR_SPACE(ADDR_SPACE_DEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt = 0;
    int check_cnt = 0;
    int cyc = 0;
    int job_edge = 0;
    int bad_ready = 0;
    int ready_cnt = 0;
    int acc_q[$];
    int wr_edge_q[$];
    int done_q[$];
    logic [15:0]      wr_addr_q[$];
    logic [ROW_W-1:0] wr_data_q[$];

    // cyc is the number of the edge being sampled; at a negedge it names the next edge.
    always @(posedge clk) begin
        if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
        if (bus.wsb === 1'b0) begin
            wr_edge_q.push_back(cyc);
            wr_addr_q.push_back(bus.waddr);
            wr_data_q.push_back(bus.wdata);
        end
        if (bus.done === 1'b1) done_q.push_back(cyc);
        if (bus.in_ready === 1'b1) ready_cnt++;
        if (bus.in_ready === 1'b1 && (bus.busy !== 1'b1 || bus.wsb !== 1'b1)) bad_ready++;
        cyc++;
    end

    function automatic logic [15:0] chunk_val(input int mode, input int k);
        case (mode)
            0:       return 16'(k);
            1:       return (k < 16) ? 16'hA5A5 : 16'h5A5A;
            default: return 16'h0100 + 16'(k);
        endcase
    endfunction

    function automatic logic [ROW_W-1:0] exp_row(input int mode, input int row);
        logic [ROW_W-1:0] r = '0;
        for (int i = 0; i < CPW; i++)
            r[ROW_W-1-i*IN_W_DEF -: IN_W_DEF] = chunk_val(mode, row*CPW + i);
        return r;
    endfunction

    task automatic clear_logs();
        acc_q.delete(); wr_edge_q.delete(); done_q.delete();
        wr_addr_q.delete(); wr_data_q.delete();
        bad_ready = 0; ready_cnt = 0;
    endtask

    task automatic start_job(input logic [15:0] base, input logic [16:0] n);
        @(negedge clk);
        bus.base_addr = base;
        bus.num_words = n;
        bus.start = 1'b1;
        job_edge = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Call at a negedge; returns just after the edge that accepts the last chunk.
    task automatic applyStimulus(input int total, input int mode, input int bp_pct,
                                 input int glitch_at, output int got);
        int k = 0;
        int guard = 0;
        bit acc;
        bit glitched = 1'b0;
        while (k < total && guard < 4000) begin
            bus.in_valid = ($urandom_range(0, 99) >= bp_pct);
            bus.in_data = chunk_val(mode, k);
            if (k == glitch_at && !glitched) begin
                bus.start = 1'b1;
                bus.base_addr = 16'h0100;
                bus.num_words = 17'd1;
                glitched = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (acc) k++;
            guard++;
            if (k < total && guard < 4000) @(negedge clk);
        end
        got = k;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (done_q.size() == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (done_q.size() != 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        check_cnt++; if (bus.wsb !== 1'b1) $display("[TB] FAIL reset_wsb: got %b want 1", bus.wsb); else pass_cnt++;
        check_cnt++; if (bus.waddr !== 16'h0000) $display("[TB] FAIL reset_waddr: got %h want 0000", bus.waddr); else pass_cnt++;
        check_cnt++; if (bus.wdata !== '0) $display("[TB] FAIL reset_wdata: got %h want 0", bus.wdata); else pass_cnt++;
        check_cnt++; if ({bus.in_ready, bus.busy, bus.done} !== 3'b000) $display("[TB] FAIL reset_status: got %b want 000", {bus.in_ready, bus.busy, bus.done}); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int got; bit ok; int e0;
        clear_logs();
        start_job(16'h0010, 17'd2);
        e0 = job_edge;
        applyStimulus(32, 0, 0, -1, got);
        @(negedge clk); bus.in_valid = 1'b0;
        wait_done(60, ok);
        check_cnt++; if (ok !== 1'b1 || got !== 32) $display("[TB] FAIL basic_timeout: got chunks %0d done %b want 32 1", got, ok); else pass_cnt++;
        check_cnt++; if (acc_q.size() !== 32) $display("[TB] FAIL basic_accept_count: got %0d want 32", acc_q.size()); else pass_cnt++;
        if (acc_q.size() == 32) begin
            check_cnt++; if ({acc_q[0]-e0, acc_q[15]-e0, acc_q[16]-e0, acc_q[31]-e0} !== {32'd1, 32'd16, 32'd18, 32'd33})
                $display("[TB] FAIL basic_accept_edges: got %0d %0d %0d %0d want 1 16 18 33", acc_q[0]-e0, acc_q[15]-e0, acc_q[16]-e0, acc_q[31]-e0); else pass_cnt++;
        end
        check_cnt++; if (wr_edge_q.size() !== 2) $display("[TB] FAIL basic_write_count: got %0d want 2", wr_edge_q.size()); else pass_cnt++;
        if (wr_edge_q.size() == 2) begin
            check_cnt++; if ({wr_edge_q[0]-e0, wr_edge_q[1]-e0} !== {32'd17, 32'd34}) $display("[TB] FAIL basic_wsb_timing: got low before edges %0d %0d want 17 34", wr_edge_q[0]-e0, wr_edge_q[1]-e0); else pass_cnt++;
            check_cnt++; if ({wr_addr_q[0], wr_addr_q[1]} !== {16'h0010, 16'h0011}) $display("[TB] FAIL basic_addr: got %h %h want 0010 0011", wr_addr_q[0], wr_addr_q[1]); else pass_cnt++;
            check_cnt++; if (wr_data_q[0] !== exp_row(0, 0)) $display("[TB] FAIL basic_row0: got %h want %h", wr_data_q[0], exp_row(0, 0)); else pass_cnt++;
            check_cnt++; if (wr_data_q[1] !== exp_row(0, 1)) $display("[TB] FAIL basic_row1: got %h want %h", wr_data_q[1], exp_row(0, 1)); else pass_cnt++;
        end
        check_cnt++; if (done_q.size() !== 1 || (done_q.size() == 1 && done_q[0]-e0 !== 35)) $display("[TB] FAIL basic_done: got %0d pulses first %0d want 1 at 35", done_q.size(), (done_q.size() > 0) ? done_q[0]-e0 : -1); else pass_cnt++;
        check_cnt++; if ({bus.busy, bus.done, bus.in_ready} !== 3'b000) $display("[TB] FAIL basic_idle: got busy/done/ready %b want 000", {bus.busy, bus.done, bus.in_ready}); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int got; bit ok;
        clear_logs();
        start_job(16'h0010, 17'd2);
        applyStimulus(32, 0, 50, -1, got);
        @(negedge clk); bus.in_valid = 1'b0;
        wait_done(60, ok);
        check_cnt++; if (ok !== 1'b1 || got !== 32) $display("[TB] FAIL bp_timeout: got chunks %0d done %b want 32 1", got, ok); else pass_cnt++;
        check_cnt++; if (wr_data_q.size() !== 2) $display("[TB] FAIL bp_write_count: got %0d want 2", wr_data_q.size()); else pass_cnt++;
        if (wr_data_q.size() == 2) begin
            check_cnt++; if ({wr_addr_q[0], wr_addr_q[1]} !== {16'h0010, 16'h0011}) $display("[TB] FAIL bp_addr: got %h %h want 0010 0011", wr_addr_q[0], wr_addr_q[1]); else pass_cnt++;
            check_cnt++; if ({wr_data_q[0], wr_data_q[1]} !== {exp_row(0, 0), exp_row(0, 1)}) $display("[TB] FAIL bp_rows: got %h %h", wr_data_q[0], wr_data_q[1]); else pass_cnt++;
        end
        check_cnt++; if (bad_ready !== 0) $display("[TB] FAIL bp_ready_outside_fill: got %0d cycles want 0", bad_ready); else pass_cnt++;
    endtask

    task automatic test_zero_rows();
        int e0;
        clear_logs();
        start_job(16'h0200, 17'd0);
        e0 = job_edge;
        check_cnt++; if (bus.done !== 1'b1) $display("[TB] FAIL zero_done_now: got %b want 1", bus.done); else pass_cnt++;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        check_cnt++; if (done_q.size() !== 1 || (done_q.size() == 1 && done_q[0]-e0 !== 1)) $display("[TB] FAIL zero_done_pulses: got %0d pulses want 1 at edge 1", done_q.size()); else pass_cnt++;
        check_cnt++; if (wr_edge_q.size() !== 0 || ready_cnt !== 0) $display("[TB] FAIL zero_no_activity: got writes %0d ready %0d want 0 0", wr_edge_q.size(), ready_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid_fill();
        int got; bit ok;
        clear_logs();
        start_job(16'h0030, 17'd1);
        applyStimulus(5, 0, 0, -1, got);
        #3;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check_cnt++; if ({bus.wsb, bus.in_ready, bus.busy, bus.done} !== 4'b1000) $display("[TB] FAIL rst_async_status: got %b want 1000", {bus.wsb, bus.in_ready, bus.busy, bus.done}); else pass_cnt++;
        check_cnt++; if (bus.waddr !== 16'h0000 || bus.wdata !== '0) $display("[TB] FAIL rst_async_bus: got waddr %h want 0000", bus.waddr); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_cnt++; if (wr_edge_q.size() !== 0) $display("[TB] FAIL rst_no_write: got %0d writes want 0", wr_edge_q.size()); else pass_cnt++;
        clear_logs();
        start_job(16'h0020, 17'd1);
        applyStimulus(16, 2, 0, -1, got);
        @(negedge clk); bus.in_valid = 1'b0;
        wait_done(40, ok);
        check_cnt++; if (ok !== 1'b1 || wr_edge_q.size() !== 1) $display("[TB] FAIL rst_restart_write: got %0d writes done %b want 1 1", wr_edge_q.size(), ok); else pass_cnt++;
        if (wr_edge_q.size() == 1) begin
            check_cnt++; if (wr_addr_q[0] !== 16'h0020 || wr_data_q[0] !== exp_row(2, 0)) $display("[TB] FAIL rst_restart_row: got %h @%h want %h @0020", wr_data_q[0], wr_addr_q[0], exp_row(2, 0)); else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        int got; bit ok;
        clear_logs();
        start_job(16'hFFFF, 17'd2);
        applyStimulus(32, 1, 0, -1, got);
        @(negedge clk); bus.in_valid = 1'b0;
        wait_done(60, ok);
        check_cnt++; if (ok !== 1'b1 || wr_edge_q.size() !== 2) $display("[TB] FAIL wrap_writes: got %0d writes done %b want 2 1", wr_edge_q.size(), ok); else pass_cnt++;
        if (wr_edge_q.size() == 2) begin
            check_cnt++; if ({wr_addr_q[0], wr_addr_q[1]} !== {16'hFFFF, 16'h0000}) $display("[TB] FAIL wrap_addr: got %h %h want ffff 0000", wr_addr_q[0], wr_addr_q[1]); else pass_cnt++;
            check_cnt++; if (wr_data_q[0] !== {16{16'hA5A5}} || wr_data_q[1] !== {16{16'h5A5A}}) $display("[TB] FAIL wrap_rows: got %h %h", wr_data_q[0], wr_data_q[1]); else pass_cnt++;
        end
    endtask

    task automatic test_start_while_busy();
        int got; bit ok;
        clear_logs();
        start_job(16'h0040, 17'd1);
        applyStimulus(16, 0, 0, 8, got);
        @(negedge clk); bus.in_valid = 1'b0; bus.start = 1'b0;
        wait_done(40, ok);
        repeat (20) @(negedge clk);
        check_cnt++; if (ok !== 1'b1 || done_q.size() !== 1) $display("[TB] FAIL busy_done_pulses: got %0d want 1", done_q.size()); else pass_cnt++;
        check_cnt++; if (wr_edge_q.size() !== 1 || (wr_edge_q.size() == 1 && wr_addr_q[0] !== 16'h0040)) $display("[TB] FAIL busy_single_write: got %0d writes want 1 at 0040", wr_edge_q.size()); else pass_cnt++;
        check_cnt++; if (bus.busy !== 1'b0) $display("[TB] FAIL busy_back_idle: got busy %b want 0", bus.busy); else pass_cnt++;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.num_words = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_rows();
        test_reset_mid_fill();
        test_wrap();
        test_start_while_busy();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
